wb_ctrl: RTL and testbench

- Writer side of the integer register file: arbitrates ALU and load results onto the single write port (rd/wen/wdata).
- Formats raw load words with byte/halfword select and sign/zero extension.
- Keeps a pending-load scoreboard so decode stalls on RAW/WAW hazards against outstanding loads.
- Sits between execute/LSU and the register file; its registered outputs drive the register-file write port directly.

---
 rtl/rv32i_pkg.sv | 20 ++
 rtl/load_ext.sv | 40 ++++
 rtl/wb_ctrl.sv | 124 ++++++++++++
 tb/tb_wb_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared integer-pipeline constants, load-type encodings and the
// register-file write entry used by the writeback controller.
package rv32i_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/load_ext.sv
// Load response formatter: byte/halfword lane select, sign or zero
// extension, and misalignment detection.
module load_ext
  import rv32i_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] data,
  output logic [XLEN-1:0] value,
  output logic            misalign
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v   = data[{off, 3'b000} +: 8];
    half_v   = off[1] ? data[31:16] : data[15:0];
    value    = data;
    misalign = 1'b0;
    case (funct3)
      F3_LB:  value = {{24{byte_v[7]}}, byte_v};
      F3_LBU: value = {24'h0, byte_v};
      F3_LH: begin
        value    = {{16{half_v[15]}}, half_v};
        misalign = off[0];
      end
      F3_LHU: begin
        value    = {16'h0, half_v};
        misalign = off[0];
      end
      // LW and the unused encodings behave as a full-word load
      default: begin
        value    = data;
        misalign = (off != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/wb_ctrl.sv
// Register-file write-port arbiter: loads win, queued ALU results next,
// then a bypassing ALU result; tracks outstanding loads for decode stalls.
module wb_ctrl
  import rv32i_pkg::*;
#(
  parameter int DataWidth    = XLEN,
  parameter int Registers    = NUM_REGS,
  parameter int AddrRegWidth = REG_ADDR_W,
  parameter int AluQDepth    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [AddrRegWidth-1:0] alu_rd,
  input  logic [DataWidth-1:0]    alu_data,
  input  logic                    ld_valid,
  input  logic [AddrRegWidth-1:0] ld_rd,
  input  logic [2:0]              ld_funct3,
  input  logic [1:0]              ld_off,
  input  logic [DataWidth-1:0]    ld_data,
  input  logic                    iss_valid,
  input  logic [AddrRegWidth-1:0] iss_rd,
  input  logic [AddrRegWidth-1:0] chk_rs1,
  input  logic [AddrRegWidth-1:0] chk_rs2,
  input  logic [AddrRegWidth-1:0] chk_rd,
  output logic                    stall,
  output logic [AddrRegWidth-1:0] rd,
  output logic                    wen,
  output logic [DataWidth-1:0]    wdata,
  output logic                    misalign_err
);

  localparam int PtrW = $clog2(AluQDepth);
  localparam logic [PtrW:0] QFull = (PtrW + 1)'(AluQDepth);

  wb_entry_t             q [AluQDepth];
  logic [PtrW-1:0]       head, tail;
  logic [PtrW:0]         count;
  logic [Registers-1:0]  pending, pending_nxt;

  logic                  q_full, q_empty, alu_acc, enq, deq;
  logic                  sel_valid, sel_is_ld;
  wb_entry_t             sel;
  logic [DataWidth-1:0]  ld_value;
  logic                  ld_misalign;

  load_ext u_load_ext (
    .funct3   (ld_funct3),
    .off      (ld_off),
    .data     (ld_data),
    .value    (ld_value),
    .misalign (ld_misalign)
  );

  assign q_full    = (count == QFull);
  assign q_empty   = (count == '0);
  assign alu_ready = !q_full;
  assign alu_acc   = alu_valid && alu_ready;

  always_comb begin
    sel       = '0;
    sel_valid = 1'b0;
    sel_is_ld = 1'b0;
    enq       = 1'b0;
    deq       = 1'b0;
    if (ld_valid) begin
      sel       = '{rd: ld_rd, data: ld_value};
      sel_valid = 1'b1;
      sel_is_ld = 1'b1;
      enq       = alu_acc;
    end else if (!q_empty) begin
      sel       = q[head];
      sel_valid = 1'b1;
      deq       = 1'b1;
      enq       = alu_acc;
    end else if (alu_acc) begin
      sel       = '{rd: alu_rd, data: alu_data};
      sel_valid = 1'b1;
    end
  end

  // Set wins over clear when the same register is issued and returned together.
  always_comb begin
    pending_nxt = pending;
    if (ld_valid) pending_nxt[ld_rd] = 1'b0;
    if (iss_valid && iss_rd != '0) pending_nxt[iss_rd] = 1'b1;
  end

  assign stall = (pending[chk_rs1] && chk_rs1 != '0) ||
                 (pending[chk_rs2] && chk_rs2 != '0) ||
                 (pending[chk_rd]  && chk_rd  != '0) ||
                 q_full;

  always_ff @(posedge clk) begin
    if (enq) q[tail] <= '{rd: alu_rd, data: alu_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      pending      <= '0;
      rd           <= '0;
      wen          <= 1'b0;
      wdata        <= '0;
      misalign_err <= 1'b0;
    end else begin
      if (enq) tail <= tail + 1'b1;
      if (deq) head <= head + 1'b1;
      if (enq && !deq)      count <= count + 1'b1;
      else if (deq && !enq) count <= count - 1'b1;
      pending      <= pending_nxt;
      wen          <= sel_valid && (sel.rd != '0) && !(sel_is_ld && ld_misalign);
      misalign_err <= ld_valid && ld_misalign;
      if (sel_valid) begin
        rd    <= sel.rd;
        wdata <= sel.data;
      end
    end
  end

endmodule

// File: tb/tb_wb_ctrl.sv
// Directed-vector bench for wb_ctrl with hand-computed expectations.
module tb_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_off;
  logic [31:0] ld_data;
  logic        iss_valid;
  logic [4:0]  iss_rd, chk_rs1, chk_rs2, chk_rd;
  logic        stall;
  logic [4:0]  rd;
  logic        wen;
  logic [31:0] wdata;
  logic        misalign_err;

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  wb_ctrl dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_funct3(ld_funct3), .ld_off(ld_off), .ld_data(ld_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
    .stall(stall), .rd(rd), .wen(wen), .wdata(wdata), .misalign_err(misalign_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_valid = 0; ld_rd = 0; ld_funct3 = 0; ld_off = 0; ld_data = 0;
    iss_valid = 0; iss_rd = 0;
    chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0;
  endtask

  task automatic drive_ld(input logic [4:0] r, input logic [2:0] f3,
                          input logic [1:0] off, input logic [31:0] d);
    ld_valid = 1; ld_rd = r; ld_funct3 = f3; ld_off = off; ld_data = d;
  endtask

  task automatic drive_alu(input logic [4:0] r, input logic [31:0] d);
    alu_valid = 1; alu_rd = r; alu_data = d;
  endtask

  task automatic chk_write(input string tag, input logic [4:0] r, input logic [31:0] d);
    chk({tag, "_wen"}, {31'b0, wen}, 32'd1);
    chk({tag, "_rd"}, {27'b0, rd}, {27'b0, r});
    chk({tag, "_wdata"}, wdata, d);
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] exp;
  } ld_vec_t;

  ld_vec_t lvec[7] = '{
    '{3'd0, 2'd1, 32'h0000007F},
    '{3'd0, 2'd3, 32'hFFFFFF80},
    '{3'd4, 2'd2, 32'h000000FF},
    '{3'd1, 2'd2, 32'hFFFF80FF},
    '{3'd5, 2'd2, 32'h000080FF},
    '{3'd1, 2'd0, 32'h00007F01},
    '{3'd3, 2'd0, 32'h80FF7F01}
  };

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wen", {31'b0, wen}, 32'd0);
    chk("rst_rd", {27'b0, rd}, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_mis", {31'b0, misalign_err}, 32'd0);
    rst = 0;
    #1;
    chk("rst_ready", {31'b0, alu_ready}, 32'd1);
    chk("rst_stall", {31'b0, stall}, 32'd0);

    // Lone ALU result bypasses the queue
    cyc();
    drive_alu(5, 32'h1234);
    #1 chk("alu1_ready", {31'b0, alu_ready}, 32'd1);
    cyc(); idle();
    chk_write("alu1", 5, 32'h00001234);
    cyc();
    chk("alu1_onepulse", {31'b0, wen}, 32'd0);
    chk("alu1_qempty", {31'b0, stall}, 32'd0);

    // Load beats ALU; ALU follows next cycle
    drive_ld(3, 3'd2, 2'd0, 32'hDEADBEEF);
    drive_alu(4, 32'h11);
    cyc(); idle();
    chk_write("ldalu_ld", 3, 32'hDEADBEEF);
    cyc();
    chk_write("ldalu_alu", 4, 32'h00000011);
    cyc();
    chk("ldalu_done", {31'b0, wen}, 32'd0);

    // Load formatting
    foreach (lvec[i]) begin
      drive_ld(9, lvec[i].f3, lvec[i].off, 32'h80FF7F01);
      cyc(); idle();
      chk_write($sformatf("fmt%0d", i), 9, lvec[i].exp);
    end
    cyc();

    // x0 destination is consumed without a write
    drive_alu(0, 32'h55);
    cyc(); idle();
    chk("x0_wen", {31'b0, wen}, 32'd0);

    // Scoreboard
    iss_valid = 1; iss_rd = 7;
    cyc(); idle();
    chk_rs1 = 7;
    #1 chk("sb_rs1_stall", {31'b0, stall}, 32'd1);
    cyc();
    chk("sb_rs1_hold", {31'b0, stall}, 32'd1);
    chk_rs1 = 0; chk_rs2 = 7;
    #1 chk("sb_rs2_stall", {31'b0, stall}, 32'd1);
    chk_rs2 = 0; chk_rd = 7;
    #1 chk("sb_rd_stall", {31'b0, stall}, 32'd1);
    chk_rd = 0; chk_rs1 = 7;
    drive_ld(7, 3'd2, 2'd0, 32'h00000077);
    #1 chk("sb_resp_cycle", {31'b0, stall}, 32'd1);
    cyc(); ld_valid = 0;
    #1 chk("sb_cleared", {31'b0, stall}, 32'd0);
    chk_write("sb_ldwr", 7, 32'h00000077);
    chk_rs1 = 0;
    #1 chk("sb_x0", {31'b0, stall}, 32'd0);
    idle();
    iss_valid = 1; iss_rd = 8;
    drive_ld(8, 3'd2, 2'd0, 32'h8);
    cyc(); idle();
    chk_rd = 8;
    #1 chk("sb_set_wins", {31'b0, stall}, 32'd1);
    drive_ld(8, 3'd2, 2'd0, 32'h8);
    cyc(); idle();
    chk_rd = 8;
    #1 chk("sb_clear8", {31'b0, stall}, 32'd0);
    idle();
    cyc();

    // Back-pressure while loads hold the port
    drive_ld(10, 3'd2, 2'd0, 32'hA0);
    drive_alu(11, 32'hB1);
    #1 chk("bp_c0_ready", {31'b0, alu_ready}, 32'd1);
    cyc();
    drive_ld(12, 3'd2, 2'd0, 32'hA2);
    drive_alu(13, 32'hB3);
    chk_write("bp_c1", 10, 32'hA0);
    chk("bp_c1_ready", {31'b0, alu_ready}, 32'd1);
    cyc();
    drive_ld(14, 3'd2, 2'd0, 32'hA4);
    drive_alu(15, 32'hB5);
    chk_write("bp_c2", 12, 32'hA2);
    chk("bp_c2_ready", {31'b0, alu_ready}, 32'd0);
    chk("bp_c2_stall", {31'b0, stall}, 32'd1);
    cyc();
    ld_valid = 0;
    chk_write("bp_c3", 14, 32'hA4);
    #1 chk("bp_c3_ready", {31'b0, alu_ready}, 32'd0);
    cyc();
    chk_write("bp_c4", 11, 32'hB1);
    chk("bp_c4_ready", {31'b0, alu_ready}, 32'd1);
    cyc(); idle();
    chk_write("bp_c5", 13, 32'hB3);
    cyc();
    chk_write("bp_c6", 15, 32'hB5);
    cyc();
    chk("bp_c7_idle", {31'b0, wen}, 32'd0);
    chk("bp_c7_stall", {31'b0, stall}, 32'd0);

    // Misaligned word load
    iss_valid = 1; iss_rd = 6;
    cyc(); idle();
    drive_ld(6, 3'd2, 2'd1, 32'hCAFEF00D);
    cyc(); idle();
    chk_rs1 = 6;
    #1;
    chk("mis_wen", {31'b0, wen}, 32'd0);
    chk("mis_err", {31'b0, misalign_err}, 32'd1);
    chk("mis_sb", {31'b0, stall}, 32'd0);
    cyc();
    chk("mis_pulse", {31'b0, misalign_err}, 32'd0);
    idle();

    // Async reset with the queue full and a load pending
    drive_ld(21, 3'd2, 2'd0, 32'h77);
    drive_alu(22, 32'hC2);
    iss_valid = 1; iss_rd = 20;
    cyc();
    iss_valid = 0;
    drive_ld(23, 3'd2, 2'd0, 32'h79);
    drive_alu(24, 32'hC4);
    cyc(); idle();
    chk("rstm_pre_wen", {31'b0, wen}, 32'd1);
    chk("rstm_pre_full", {31'b0, alu_ready}, 32'd0);
    #2 rst = 1;
    #1;
    chk("rstm_wen", {31'b0, wen}, 32'd0);
    chk("rstm_rd", {27'b0, rd}, 32'd0);
    chk("rstm_wdata", wdata, 32'd0);
    cyc(); cyc();
    rst = 0;
    chk_rs1 = 20;
    #1;
    chk("rstm_ready", {31'b0, alu_ready}, 32'd1);
    chk("rstm_sb", {31'b0, stall}, 32'd0);
    cyc();
    chk("rstm_nodrain1", {31'b0, wen}, 32'd0);
    cyc();
    chk("rstm_nodrain2", {31'b0, wen}, 32'd0);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
